fifo_rr_drain_arbiter: RTL and testbench

- Round-robin drain scheduler that merges the read sides of PORTS independent simple FIFOs onto one shared output stream.
- Each FIFO's dout/dout_valid/dout_ready connects to one input port.
- Grants are burst-based (up to MAX_BURST beats per grant) with a per-port enable mask.
- Output goes through one registered pipeline stage that tags each beat with its source port. Sits between per-core queues and a shared downstream consumer (DMA/interconnect).

---
 rtl/fifo_rr_drain_arbiter.sv | 164 ++++++++++++++++
 tb/tb_fifo_rr_drain_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin burst drain scheduler: merges the read sides of PORTS FIFOs
// onto one registered output stream, tagging each beat with its source port.
module fifo_rr_drain_arbiter #(
    parameter int unsigned PORTS      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 8,
    parameter int unsigned PORT_WIDTH = $clog2(PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS-1:0]            s_valid,
    input  logic [PORTS*DATA_WIDTH-1:0] s_data,
    output logic [PORTS-1:0]            s_ready,
    input  logic [PORTS-1:0]            enable,
    output logic                        m_valid,
    output logic [DATA_WIDTH-1:0]       m_data,
    output logic [PORT_WIDTH-1:0]       m_port,
    input  logic                        m_ready,
    output logic                        busy,
    output logic [PORT_WIDTH-1:0]       grant
);

    localparam int unsigned BEAT_WIDTH = $clog2(MAX_BURST + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]            r_state;
    logic [PORT_WIDTH-1:0] r_grant;
    logic [PORT_WIDTH-1:0] r_rr_ptr;
    logic [BEAT_WIDTH-1:0] r_beat_cnt;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic [PORT_WIDTH-1:0] r_m_port;

    logic [0:0]            w_state_nxt;
    logic [PORT_WIDTH-1:0] w_grant_nxt;
    logic [PORT_WIDTH-1:0] w_rr_nxt;
    logic [BEAT_WIDTH-1:0] w_beat_nxt;

    logic                  w_busy;
    logic                  w_load;
    logic                  w_xfer;
    logic                  w_gnt_valid;
    logic                  w_gnt_en;
    logic [PORTS-1:0]      w_gnt_onehot;
    logic [DATA_WIDTH-1:0] w_src_data;
    logic [PORTS-1:0]      w_cand;
    logic [2*PORTS-1:0]    w_rot;
    logic                  w_sel_found;
    logic [PORT_WIDTH-1:0] w_sel;
    logic [PORT_WIDTH-1:0] w_rr_after;
    int unsigned           v_pos;
    int unsigned           v_idx;

    assign w_busy  = (r_state == S_BURST);
    assign w_load  = !r_m_valid || m_ready;
    assign w_xfer  = w_busy && w_gnt_en && w_gnt_valid && w_load;
    assign busy    = w_busy;
    assign grant   = r_grant;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_port  = r_m_port;

    // Decode the granted port: one-hot, its valid/enable, its data, and the dequeue strobes
    always_comb begin
        w_gnt_onehot = '0;
        w_src_data   = '0;
        s_ready      = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (r_grant == PORT_WIDTH'(i)) begin
                w_gnt_onehot[i] = 1'b1;
                w_src_data      = s_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            s_ready[i] = w_busy && (r_grant == PORT_WIDTH'(i)) && enable[i] && w_load;
        end
        w_gnt_valid = |(s_valid & w_gnt_onehot);
        w_gnt_en    = |(enable & w_gnt_onehot);
    end

    // Round-robin pick: first enabled, non-empty port at or after r_rr_ptr, with wrap
    always_comb begin
        w_cand      = s_valid & enable;
        w_rot       = {w_cand, w_cand} >> r_rr_ptr;
        w_sel_found = 1'b0;
        v_pos       = 0;
        for (int unsigned k = 0; k < PORTS; k++) begin
            if (!w_sel_found && w_rot[k]) begin
                w_sel_found = 1'b1;
                v_pos       = k;
            end
        end
        v_idx = 32'(r_rr_ptr) + v_pos;
        if (v_idx >= PORTS) begin
            v_idx = v_idx - PORTS;
        end
        w_sel = PORT_WIDTH'(v_idx);
    end

    // Pointer after the current grant, wrapping correctly for any PORTS
    assign w_rr_after = (r_grant == PORT_WIDTH'(PORTS - 1)) ? '0 : r_grant + 1'b1;

    // Next-state logic: IDLE arbitrates, BURST drains until limit, empty source or disable
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        w_beat_nxt  = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_sel_found) begin
                    w_grant_nxt = w_sel;
                    w_beat_nxt  = '0;
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (!w_gnt_valid || !w_gnt_en ||
                    (w_xfer && (r_beat_cnt == BEAT_WIDTH'(MAX_BURST - 1)))) begin
                    w_state_nxt = S_IDLE;
                    w_rr_nxt    = w_rr_after;
                end else if (w_xfer) begin
                    w_beat_nxt = r_beat_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_beat_cnt <= w_beat_nxt;
        end
    end

    // Output pipeline stage: capture on transfer, drain when consumed, hold on stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_port  <= '0;
        end else if (w_load) begin
            if (w_xfer) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_src_data;
                r_m_port  <= r_grant;
            end else begin
                r_m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// Directed bench for fifo_rr_drain_arbiter: FIFO models feed two instances
// (4 ports / burst 8 and 3 ports / burst 1); output beats are compared in order.
module tb_fifo_rr_drain_arbiter;

    logic clk;
    logic rst;

    logic [3:0]   s_valid;
    logic [127:0] s_data;
    logic [3:0]   s_ready;
    logic [3:0]   enable;
    logic         m_valid;
    logic [31:0]  m_data;
    logic [1:0]   m_port;
    logic         m_ready;
    logic         busy;
    logic [1:0]   grant;

    logic [2:0]   s3_valid;
    logic [95:0]  s3_data;
    logic [2:0]   s3_ready;
    logic [2:0]   en3;
    logic         m3_valid;
    logic [31:0]  m3_data;
    logic [1:0]   m3_port;
    logic         m3_ready;
    logic         busy3;
    logic [1:0]   grant3;

    fifo_rr_drain_arbiter #(.PORTS(4), .DATA_WIDTH(32), .MAX_BURST(8)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .enable(enable), .m_valid(m_valid), .m_data(m_data), .m_port(m_port),
        .m_ready(m_ready), .busy(busy), .grant(grant)
    );

    fifo_rr_drain_arbiter #(.PORTS(3), .DATA_WIDTH(32), .MAX_BURST(1)) dut3 (
        .clk(clk), .rst(rst), .s_valid(s3_valid), .s_data(s3_data), .s_ready(s3_ready),
        .enable(en3), .m_valid(m3_valid), .m_data(m3_data), .m_port(m3_port),
        .m_ready(m3_ready), .busy(busy3), .grant(grant3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // source FIFO models
    logic [31:0] mem  [4][64];
    int          head [4];
    int          tail [4];
    logic [31:0] mem3 [3][8];
    int          head3[3];
    int          tail3[3];

    // expected-order bookkeeping and observed output log
    int          nxt[4];
    logic [1:0]  exp_port[$];
    logic [31:0] exp_data[$];
    logic [1:0]  obs_port[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];
    logic [1:0]  obs3_port[$];

    logic [3:0]  rdy_seen;
    int          xfer_cnt[4];
    logic        smp_m_valid;
    logic [31:0] smp_m_data;
    logic [3:0]  smp_s_ready;
    logic        smp_busy;
    logic        smp3_m_valid;
    logic        smp3_busy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mk(input int p, input int n);
        logic [31:0] v;
        v = {8'hD0, p[7:0], n[15:0]};
        return v;
    endfunction

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            s_valid[i]          = (head[i] != tail[i]);
            s_data[i*32 +: 32]  = mem[i][head[i]];
        end
        for (int i = 0; i < 3; i++) begin
            s3_valid[i]         = (head3[i] != tail3[i]);
            s3_data[i*32 +: 32] = mem3[i][head3[i]];
        end
    endtask

    task automatic push(input int p, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            mem[p][tail[p]] = mk(p, tail[p]);
            tail[p]++;
        end
        refresh();
    endtask

    task automatic push3(input int p, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            mem3[p][tail3[p]] = mk(p, tail3[p]);
            tail3[p]++;
        end
        refresh();
    endtask

    task automatic expect_beats(input int p, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            exp_port.push_back(p[1:0]);
            exp_data.push_back(mk(p, nxt[p]));
            nxt[p]++;
        end
    endtask

    // one clock: sample at negedge, then apply FIFO pops just after posedge
    task automatic tick();
        logic [3:0] pop;
        logic [2:0] pop3;
        @(negedge clk);
        pop          = s_ready & s_valid;
        pop3         = s3_ready & s3_valid;
        smp_m_valid  = m_valid;
        smp_m_data   = m_data;
        smp_s_ready  = s_ready;
        smp_busy     = busy;
        smp3_m_valid = m3_valid;
        smp3_busy    = busy3;
        rdy_seen     = rdy_seen | s_ready;
        if (m_valid && m_ready) begin
            obs_port.push_back(m_port);
            obs_data.push_back(m_data);
            obs_cyc.push_back(cyc);
        end
        if (m3_valid && m3_ready) obs3_port.push_back(m3_port);
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) if (pop[i]) begin head[i]++; xfer_cnt[i]++; end
        for (int i = 0; i < 3; i++) if (pop3[i]) head3[i]++;
        refresh();
    endtask

    function automatic logic model_idle();
        logic r;
        r = 1'b1;
        for (int i = 0; i < 4; i++) if (head[i] != tail[i] && enable[i]) r = 1'b0;
        for (int i = 0; i < 3; i++) if (head3[i] != tail3[i] && en3[i]) r = 1'b0;
        return r;
    endfunction

    task automatic drain(input string tag, input int max_cyc);
        logic done;
        done = 1'b0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            tick();
            done = model_idle() && !smp_busy && !smp_m_valid && !smp3_busy && !smp3_m_valid;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        tick();
        tick();
    endtask

    task automatic compare(input string tag);
        chk({tag, "_len"}, 64'(obs_port.size()), 64'(exp_port.size()));
        for (int i = 0; i < obs_port.size() && i < exp_port.size(); i++) begin
            chk($sformatf("%s_port%0d", tag, i), 64'(obs_port[i]), 64'(exp_port[i]));
            chk($sformatf("%s_data%0d", tag, i), 64'(obs_data[i]), 64'(exp_data[i]));
        end
        obs_port.delete();
        obs_data.delete();
        obs_cyc.delete();
        exp_port.delete();
        exp_data.delete();
    endtask

    initial begin
        int c2, c3, c0, c1;
        logic [31:0] hold_exp;
        for (int i = 0; i < 4; i++) begin head[i] = 0; tail[i] = 0; nxt[i] = 0; xfer_cnt[i] = 0; end
        for (int i = 0; i < 3; i++) begin head3[i] = 0; tail3[i] = 0; end
        rst      = 1'b1;
        enable   = 4'hF;
        en3      = 3'b111;
        m_ready  = 1'b1;
        m3_ready = 1'b1;
        rdy_seen = '0;
        s_data   = '0;
        s3_data  = '0;
        refresh();

        // reset state
        tick();
        tick();
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data",  64'(m_data),  64'd0);
        chk("rst_m_port",  64'(m_port),  64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_busy",    64'(busy),    64'd0);
        chk("rst_grant",   64'(grant),   64'd0);
        rst = 1'b0;
        tick();

        // two ports, short bursts, arbitration gap between them
        rdy_seen = '0;
        push(0, 3);
        push(2, 3);
        drain("t1", 60);
        chk("t1_rdy_ports", 64'(rdy_seen), 64'h5);
        c0 = (obs_cyc.size() >= 4) ? obs_cyc[0] : 0;
        c1 = (obs_cyc.size() >= 4) ? obs_cyc[1] : 0;
        c2 = (obs_cyc.size() >= 4) ? obs_cyc[2] : 0;
        c3 = (obs_cyc.size() >= 4) ? obs_cyc[3] : 0;
        chk("t1_back2back", 64'(c1 - c0), 64'd1);
        chk("t1_switch_gap", 64'(c3 - c2), 64'd3);
        expect_beats(0, 3);
        expect_beats(2, 3);
        compare("t1");

        // rr pointer sits at 3: port 3 wins over port 0
        push(0, 1);
        push(3, 1);
        drain("t1b", 40);
        expect_beats(3, 1);
        expect_beats(0, 1);
        compare("t1b");

        // long source split into MAX_BURST chunks, interleaved with port 3
        push(1, 20);
        push(3, 2);
        drain("t2", 200);
        expect_beats(1, 8);
        expect_beats(3, 2);
        expect_beats(1, 8);
        expect_beats(1, 4);
        compare("t2");

        // downstream stall mid-burst
        push(0, 6);
        hold_exp = mk(0, nxt[0] + 2);
        for (int c = 0; c < 50 && obs_port.size() < 2; c++) tick();
        m_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t3_hold_valid", 64'(smp_m_valid), 64'd1);
            chk("t3_hold_data",  64'(smp_m_data),  64'(hold_exp));
            chk("t3_hold_rdy",   64'(smp_s_ready), 64'd0);
            chk("t3_hold_busy",  64'(smp_busy),    64'd1);
        end
        m_ready = 1'b1;
        drain("t3", 60);
        expect_beats(0, 6);
        compare("t3");

        // disable port 1 on its third beat
        for (int i = 0; i < 4; i++) xfer_cnt[i] = 0;
        push(1, 5);
        push(2, 2);
        for (int c = 0; c < 50 && xfer_cnt[1] < 2; c++) tick();
        enable[1] = 1'b0;
        drain("t4", 60);
        chk("t4_p1_left", 64'(tail[1] - head[1]), 64'd3);
        expect_beats(1, 2);
        expect_beats(2, 2);
        compare("t4");
        enable = 4'hF;
        drain("t4b", 60);
        expect_beats(1, 3);
        compare("t4b");

        // synchronous reset in the middle of a burst
        push(3, 5);
        for (int c = 0; c < 50 && !(smp_m_valid && smp_busy); c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_m_valid", 64'(m_valid), 64'd0);
        chk("t6_busy",    64'(busy),    64'd0);
        chk("t6_grant",   64'(grant),   64'd0);
        chk("t6_s_ready", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1;
        drain("t6", 60);
        obs_port.delete();
        obs_data.delete();
        obs_cyc.delete();
        nxt[3] = tail[3];

        // three ports, single-beat grants, wrap-around order
        obs3_port.delete();
        for (int p = 0; p < 3; p++) push3(p, 2);
        drain("t5", 60);
        chk("t5_len", 64'(obs3_port.size()), 64'd6);
        for (int i = 0; i < obs3_port.size() && i < 6; i++)
            chk($sformatf("t5_port%0d", i), 64'(obs3_port[i]), 64'(i % 3));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
